en_sequencer: RTL and testbench

Power-up enable sequencer for the cochlea comparator array. Its `en_i` input is driven by the tie-high cell's output, so after reset it always sees a constant 1. From that it brings up the analog front end in order: first the shared bias, then each comparator channel's level-shifter enable, one channel at a time, with a programmable settle interval between steps. It also handles orderly shutdown if `en_i` falls.

---
 rtl/en_sequencer_pkg.sv | 14 +
 rtl/en_sequencer_settle_timer.sv | 30 +++
 rtl/en_sequencer.sv | 112 +++++++++++
 tb/tb_en_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/en_sequencer_pkg.sv
// Shared constants for the comparator-array power-up sequencer:
// state encoding and default geometry.
package en_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BIAS = 3'd1;
    localparam logic [2:0] ST_RAMP = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_SHUT = 3'd4;

    localparam int NCH_DEF      = 8;
    localparam int SETTLE_W_DEF = 8;

endpackage

// File: rtl/en_sequencer_settle_timer.sv
// Settle-interval down-counter. A load of value v yields an expiry v cycles
// later, with v=0 treated as 1; the count parks at 0 until the next load.
module settle_timer
    import en_sequencer_pkg::*;
#(
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                load,
    input  logic [SETTLE_W-1:0] value,
    output logic                expired
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
        end else if (load) begin
            // max(value,1)-1: a zero request collapses to a one-cycle interval
            cnt <= (value == '0) ? '0 : value - SETTLE_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/en_sequencer.sv
// Power-up enable sequencer: bias first, then comparator channels one at a
// time with a settle interval between steps; orderly reverse shutdown.
module en_sequencer
    import en_sequencer_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
`ifdef USE_POWER_PINS
    inout  wire                 vccd1,
    inout  wire                 vssd1,
`endif
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                en_i,
    input  logic [SETTLE_W-1:0] settle_i,
    output logic                bias_en_o,
    output logic [NCH-1:0]      ch_en_o,
    output logic                ready_o,
    output logic                busy_o
);

    localparam int IDX_W = $clog2(NCH + 1);

    logic [2:0]       state;
    logic [IDX_W-1:0] ch_idx;
    logic             load;
    logic             expired;
    logic             shutting;

    settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (load),
        .value    (settle_i),
        .expired  (expired)
    );

    // A low enable outside IDLE preempts any pending step; once in SHUT we
    // finish regardless of enable.
    assign shutting = (state == ST_SHUT) || ((state != ST_IDLE) && !en_i);

    always_comb begin
        load = 1'b0;
        case (state)
            ST_IDLE:          load = en_i;
            ST_BIAS, ST_RAMP: load = en_i && expired;
            default:          load = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            ch_idx    <= '0;
            bias_en_o <= 1'b0;
            ch_en_o   <= '0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else if (shutting) begin
            ready_o <= 1'b0;
            if (ch_idx != '0) begin
                ch_en_o <= ch_en_o >> 1;
                ch_idx  <= ch_idx - IDX_W'(1);
                state   <= ST_SHUT;
                busy_o  <= 1'b1;
            end else begin
                bias_en_o <= 1'b0;
                state     <= ST_IDLE;
                busy_o    <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_i) begin
                        state     <= ST_BIAS;
                        bias_en_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                ST_BIAS: begin
                    if (expired) begin
                        state   <= ST_RAMP;
                        ch_en_o <= NCH'(1);
                        ch_idx  <= IDX_W'(1);
                    end
                end
                ST_RAMP: begin
                    if (expired) begin
                        if (ch_idx == IDX_W'(NCH)) begin
                            state   <= ST_RUN;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            ch_en_o <= (ch_en_o << 1) | NCH'(1);
                            ch_idx  <= ch_idx + IDX_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_en_sequencer.sv
// Directed bench for en_sequencer: ramp timing, zero settle, shutdown,
// enable glitch during shutdown, mid-ramp reset and settle reprogramming.
module tb_en_sequencer;

    logic       wb_clk_i;
    logic       wb_rst_i;
    logic       en_i;
    logic [7:0] settle_i;
    logic       bias_en_o;
    logic [7:0] ch_en_o;
    logic       ready_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    en_sequencer #(
        .NCH      (8),
        .SETTLE_W (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .en_i      (en_i),
        .settle_i  (settle_i),
        .bias_en_o (bias_en_o),
        .ch_en_o   (ch_en_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic [7:0] ch,
                           input logic r, input logic bz);
        chk({tag, ".bias"},  32'(bias_en_o), 32'(b));
        chk({tag, ".ch"},    32'(ch_en_o),   32'(ch));
        chk({tag, ".ready"}, 32'(ready_o),   32'(r));
        chk({tag, ".busy"},  32'(busy_o),    32'(bz));
    endtask

    // Channel enables must always be a thermometer code from bit 0.
    always @(negedge wb_clk_i) begin
        if (mon_on) chk("thermo", 32'(ch_en_o & (ch_en_o + 8'd1)), 32'd0);
    end

    initial begin
        wb_rst_i = 1'b1;
        en_i     = 1'b0;
        settle_i = 8'd4;
        tick(2);
        chk_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        mon_on = 1'b1;

        // Ramp with S=4
        wb_rst_i = 1'b0;
        en_i     = 1'b1;
        tick(1);
        chk_out("s4.e0", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(3);
        chk_out("s4.e3", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(1);
        chk_out("s4.e4", 1'b1, 8'h01, 1'b0, 1'b1);
        tick(4);
        chk_out("s4.e8", 1'b1, 8'h03, 1'b0, 1'b1);
        tick(24);
        chk_out("s4.e32", 1'b1, 8'hFF, 1'b0, 1'b1);
        tick(3);
        chk_out("s4.e35", 1'b1, 8'hFF, 1'b0, 1'b1);
        tick(1);
        chk_out("s4.e36", 1'b1, 8'hFF, 1'b1, 1'b0);
        tick(5);
        chk_out("s4.run", 1'b1, 8'hFF, 1'b1, 1'b0);

        // Shutdown from RUN
        en_i = 1'b0;
        tick(1);
        chk_out("shut.f1", 1'b1, 8'h7F, 1'b0, 1'b1);
        for (int k = 2; k <= 8; k++) begin
            tick(1);
            chk_out("shut.fk", 1'b1, 8'hFF >> k, 1'b0, 1'b1);
        end
        tick(1);
        chk_out("shut.f9", 1'b0, 8'h00, 1'b0, 1'b0);
        tick(2);
        chk_out("shut.idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // settle_i=0 behaves as S=1
        settle_i = 8'd0;
        en_i     = 1'b1;
        tick(1);
        chk_out("s0.e0", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(1);
        chk_out("s0.e1", 1'b1, 8'h01, 1'b0, 1'b1);
        tick(7);
        chk_out("s0.e8", 1'b1, 8'hFF, 1'b0, 1'b1);
        tick(1);
        chk_out("s0.e9", 1'b1, 8'hFF, 1'b1, 1'b0);

        // Back to IDLE, then ramp at S=2 and abort with 0x07 set
        en_i = 1'b0;
        tick(9);
        chk_out("s0.off", 1'b0, 8'h00, 1'b0, 1'b0);
        settle_i = 8'd2;
        en_i     = 1'b1;
        tick(1);
        chk_out("s2.e0", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(6);
        chk_out("s2.e6", 1'b1, 8'h07, 1'b0, 1'b1);
        en_i = 1'b0;
        tick(1);
        chk_out("abort.f1", 1'b1, 8'h03, 1'b0, 1'b1);
        en_i = 1'b1;
        tick(1);
        chk_out("abort.f2", 1'b1, 8'h01, 1'b0, 1'b1);
        tick(1);
        chk_out("abort.f3", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(1);
        chk_out("abort.f4", 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1);
        chk_out("abort.f5", 1'b1, 8'h00, 1'b0, 1'b1);

        // Reset mid-RAMP at 0x1F
        tick(10);
        chk_out("rst.pre", 1'b1, 8'h1F, 1'b0, 1'b1);
        wb_rst_i = 1'b1;
        tick(1);
        chk_out("rst.edge", 1'b0, 8'h00, 1'b0, 1'b0);
        wb_rst_i = 1'b0;
        tick(1);
        chk_out("rst.restart", 1'b1, 8'h00, 1'b0, 1'b1);

        // settle_i 4 -> 10 during BIAS
        wb_rst_i = 1'b1;
        settle_i = 8'd4;
        tick(1);
        wb_rst_i = 1'b0;
        tick(1);
        chk_out("chg.e0", 1'b1, 8'h00, 1'b0, 1'b1);
        settle_i = 8'd10;
        tick(3);
        chk_out("chg.e3", 1'b1, 8'h00, 1'b0, 1'b1);
        tick(1);
        chk_out("chg.e4", 1'b1, 8'h01, 1'b0, 1'b1);
        tick(9);
        chk_out("chg.e13", 1'b1, 8'h01, 1'b0, 1'b1);
        tick(1);
        chk_out("chg.e14", 1'b1, 8'h03, 1'b0, 1'b1);
        tick(10);
        chk_out("chg.e24", 1'b1, 8'h07, 1'b0, 1'b1);

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
